prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// Program sequencer: launches a program from a writable entry table, then steps
// the program counter (increment, PC-relative branch or halt) while counting run cycles.
module prog_sequencer #(
    parameter int PCW   = 10,
    parameter int OFFW  = 5,
    parameter int NPROG = 4,
    parameter int CW    = 16,
    localparam int SW   = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [SW-1:0]   ProgSel,
    input  logic            EntryWe,
    input  logic [SW-1:0]   EntryIdx,
    input  logic [PCW-1:0]  EntryAddr,
    input  logic            BranchEn,
    input  logic            ConditionBranch,
    input  logic            GE_Flag,
    input  logic [OFFW-1:0] BranchOffset,
    input  logic            Halt,
    output logic [PCW-1:0]  ProgCtr,
    output logic            Ack,
    output logic            Busy,
    output logic [CW-1:0]   CycleCt,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reset spreads the slots evenly over the address space.
    localparam logic [63:0] STEP = (64'd1 << PCW) / 64'(NPROG);

    state_t           state;
    logic [PCW-1:0]   entry [NPROG];
    logic [PCW-1:0]   launch_addr;
    logic [PCW-1:0]   off_ext;
    logic             taken;

    always_comb begin
        launch_addr = entry[0];
        if (32'(ProgSel) < NPROG) begin
            launch_addr = entry[ProgSel];
        end
    end

    assign off_ext   = {{(PCW-OFFW){BranchOffset[OFFW-1]}}, BranchOffset};
    assign taken     = BranchEn && (!ConditionBranch || GE_Flag);
    assign state_dbg = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
            CycleCt <= '0;
            Ack     <= 1'b0;
            Busy    <= 1'b0;
            for (int i = 0; i < NPROG; i++) begin
                entry[i] <= PCW'(64'(i) * STEP);
            end
        end else begin
            // Launches below read launch_addr, i.e. the table contents before this write.
            if (EntryWe && (32'(EntryIdx) < NPROG)) begin
                entry[EntryIdx] <= EntryAddr;
            end

            if (Start) begin
                state   <= LAUNCH;
                ProgCtr <= launch_addr;
                CycleCt <= '0;
                Ack     <= 1'b0;
                Busy    <= 1'b0;
            end else begin
                case (state)
                    LAUNCH: begin
                        state <= RUN;
                        Busy  <= 1'b1;
                    end
                    RUN: begin
                        if (Halt) begin
                            state <= DONE;
                            Ack   <= 1'b1;
                            Busy  <= 1'b0;
                        end else begin
                            if (taken) begin
                                ProgCtr <= ProgCtr + off_ext;
                            end else begin
                                ProgCtr <= ProgCtr + PCW'(1);
                            end
                            if (CycleCt != {CW{1'b1}}) begin
                                CycleCt <= CycleCt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
